// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Desc     : Two-requester round-robin arbiter feeding a 16x-oversampled UART
//            transmitter (8 data bits, LSB first, 1 stop bit). Defining
//            UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int unsigned TICK_DIV = 326
) (
    input  logic       clk50MHz,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       active_src
);

    localparam int unsigned       CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] tick_cnt_q,   tick_cnt_d;
    logic [3:0]       sub_cnt_q,    sub_cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       data_q,       data_d;
    logic             last_grant_q, last_grant_d;
    logic             active_src_q, active_src_d;

    logic tick;
    logic bit_done;
    logic winner;
    logic idle;
    logic accept;

    assign tick     = (tick_cnt_q == TICK_LAST);
    assign bit_done = tick && (sub_cnt_q == 4'd15);
    assign idle     = (state_q == S_IDLE);

    // With both requesters valid, the one not granted last time wins.
    assign winner     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = rst_n && idle && req0_valid && !winner;
    assign req1_ready = rst_n && idle && req1_valid &&  winner;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            sub_cnt_q    <= 4'd0;
            bit_idx_q    <= 3'd0;
            data_q       <= 8'd0;
            last_grant_q <= 1'b1;
            active_src_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            active_src_q <= active_src_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick ? '0 : (tick_cnt_q + CNT_W'(1));
        sub_cnt_d    = tick ? (sub_cnt_q + 4'd1) : sub_cnt_q;
        bit_idx_d    = bit_idx_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        active_src_d = active_src_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Restart bit timing so the start bit is a full period.
                    data_d       = winner ? req1_data : req0_data;
                    last_grant_d = winner;
                    active_src_d = winner;
                    tick_cnt_d   = '0;
                    sub_cnt_d    = 4'd0;
                    bit_idx_d    = 3'd0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = data_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = ^data_q;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign busy       = !idle;
    assign active_src = active_src_q;

endmodule
`default_nettype wire
